// File: rtl/parking_pkg.sv
// Shared constants, request-status encoding and the saturating bill multiply
// used by the parking billing controller.
package parking_pkg;

  localparam int DEF_RATE_STD = 10;
  localparam int DEF_RATE_CHG = 19;

  typedef enum logic [1:0] {
    ACCEPT    = 2'd0,
    ERR_OCC   = 2'd1,
    ERR_EMPTY = 2'd2,
    ERR_RANGE = 2'd3
  } req_status_t;

  // Full 64-bit product, clamped to the largest value a bill_w-bit bill can hold.
  function automatic logic [63:0] sat_mul(input logic [31:0] dur,
                                          input logic [31:0] rate,
                                          input int unsigned bill_w);
    logic [63:0] prod;
    logic [63:0] lim;
    prod = {32'd0, dur} * {32'd0, rate};
    lim  = (bill_w >= 64) ? '1 : ((64'd1 << bill_w) - 64'd1);
    return (prod > lim) ? lim : prod;
  endfunction

endpackage

// File: rtl/parking_time_base.sv
// Time base: prescaler dividing clk by TICK_DIV, driving a wrapping time counter.
module parking_time_base #(
  parameter int TIME_W   = 16,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [TIME_W-1:0] time_now,
  output logic              tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      time_now <= '0;
    end else if (tick) begin
      presc    <= '0;
      time_now <= time_now + TIME_W'(1);
    end else begin
      presc    <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/parking_billing_ctrl.sv
// Parking-lot controller: per-slot occupancy and entry timestamps, exit billing
// with wrap-safe durations and saturation, error pulses and free-slot count.
module parking_billing_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int SLOT_W    = 4,
  parameter int TIME_W    = 16,
  parameter int TICK_DIV  = 1,
  parameter int BILL_W    = 24,
  parameter int RATE_STD  = DEF_RATE_STD,
  parameter int RATE_CHG  = DEF_RATE_CHG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              entry_req,
  input  logic [SLOT_W-1:0] entry_slot,
  input  logic              want_charge,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic [TIME_W-1:0] entry_time,
  output logic [TIME_W-1:0] exit_time,
  output logic [BILL_W-1:0] total_bill,
  output logic              bill_valid,
  output logic              err_occupied,
  output logic              err_empty,
  output logic              err_range,
  output logic [SLOT_W:0]   free_count,
  output logic              full
);

  // Storage covers the whole index space so any slot value indexes safely;
  // entries at or above NUM_SLOTS are never written.
  localparam int DEPTH = 1 << SLOT_W;

  logic [DEPTH-1:0]  occ;
  logic [DEPTH-1:0]  chg;
  logic [TIME_W-1:0] ts [DEPTH];

  logic [TIME_W-1:0] time_now;
  logic              tick_unused;

  parking_time_base #(
    .TIME_W   (TIME_W),
    .TICK_DIV (TICK_DIV)
  ) u_time_base (
    .clk      (clk),
    .rst      (rst),
    .time_now (time_now),
    .tick     (tick_unused)
  );

  req_status_t       ent_st;
  req_status_t       ext_st;
  logic              ent_ok;
  logic              ext_ok;
  logic [TIME_W-1:0] dur;
  logic [31:0]       rate;
  logic [BILL_W-1:0] bill;
  logic [SLOT_W:0]   free_nxt;

  always_comb begin
    ent_st   = ACCEPT;
    ext_st   = ACCEPT;
    if (32'(exit_slot) >= NUM_SLOTS)
      ext_st = ERR_RANGE;
    else if (!occ[exit_slot])
      ext_st = ERR_EMPTY;
    ext_ok = exit_req && (ext_st == ACCEPT);

    // A same-slot exit in this cycle frees the slot for the simultaneous entry.
    if (32'(entry_slot) >= NUM_SLOTS)
      ent_st = ERR_RANGE;
    else if (occ[entry_slot] && !(ext_ok && (exit_slot == entry_slot)))
      ent_st = ERR_OCC;
    ent_ok = entry_req && (ent_st == ACCEPT);

    dur  = time_now - ts[exit_slot];
    rate = chg[exit_slot] ? 32'(RATE_CHG) : 32'(RATE_STD);
    bill = BILL_W'(sat_mul(32'(dur), rate, BILL_W));

    free_nxt = free_count;
    if (ext_ok)
      free_nxt = free_nxt + (SLOT_W+1)'(1);
    if (ent_ok)
      free_nxt = free_nxt - (SLOT_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ          <= '0;
      chg          <= '0;
      entry_time   <= '0;
      exit_time    <= '0;
      total_bill   <= '0;
      bill_valid   <= 1'b0;
      err_occupied <= 1'b0;
      err_empty    <= 1'b0;
      err_range    <= 1'b0;
      free_count   <= (SLOT_W+1)'(NUM_SLOTS);
    end else begin
      bill_valid   <= ext_ok;
      err_occupied <= entry_req && (ent_st == ERR_OCC);
      err_empty    <= exit_req && (ext_st == ERR_EMPTY);
      err_range    <= (entry_req && (ent_st == ERR_RANGE)) ||
                      (exit_req && (ext_st == ERR_RANGE));
      if (ext_ok) begin
        occ[exit_slot] <= 1'b0;
        chg[exit_slot] <= 1'b0;
        exit_time      <= time_now;
        total_bill     <= bill;
      end
      // Entry is applied after exit so a same-slot swap leaves the slot occupied.
      if (ent_ok) begin
        occ[entry_slot] <= 1'b1;
        chg[entry_slot] <= want_charge;
        entry_time      <= time_now;
      end
      free_count <= free_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ent_ok)
      ts[entry_slot] <= time_now;
  end

  assign full = (free_count == '0);

endmodule

// File: tb/tb_parking_billing_ctrl.sv
// Randomized + directed bench for parking_billing_ctrl against a slot-level
// reference model; a second instance exercises the prescaler with TICK_DIV=3.
module tb_parking_billing_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       entry_req = 1'b0, want_charge = 1'b0, exit_req = 1'b0;
  logic [4:0] entry_slot = '0, exit_slot = '0;
  logic [7:0] entry_time, exit_time, total_bill;
  logic       bill_valid, err_occupied, err_empty, err_range, full;
  logic [5:0] free_count;

  logic        b_entry_req = 1'b0, b_want_charge = 1'b0, b_exit_req = 1'b0;
  logic [3:0]  b_entry_slot = '0, b_exit_slot = '0;
  logic [15:0] b_entry_time, b_exit_time;
  logic [23:0] b_total_bill;
  logic        b_bill_valid, b_err_occupied, b_err_empty, b_err_range, b_full;
  logic [4:0]  b_free_count;

  always #5 clk = ~clk;

  parking_billing_ctrl #(
    .NUM_SLOTS(16), .SLOT_W(5), .TIME_W(8), .TICK_DIV(1), .BILL_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .entry_req(entry_req), .entry_slot(entry_slot), .want_charge(want_charge),
    .exit_req(exit_req), .exit_slot(exit_slot),
    .entry_time(entry_time), .exit_time(exit_time), .total_bill(total_bill),
    .bill_valid(bill_valid), .err_occupied(err_occupied), .err_empty(err_empty),
    .err_range(err_range), .free_count(free_count), .full(full)
  );

  parking_billing_ctrl #(.TICK_DIV(3)) dut_b (
    .clk(clk), .rst(rst),
    .entry_req(b_entry_req), .entry_slot(b_entry_slot), .want_charge(b_want_charge),
    .exit_req(b_exit_req), .exit_slot(b_exit_slot),
    .entry_time(b_entry_time), .exit_time(b_exit_time), .total_bill(b_total_bill),
    .bill_valid(b_bill_valid), .err_occupied(b_err_occupied), .err_empty(b_err_empty),
    .err_range(b_err_range), .free_count(b_free_count), .full(b_full)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: slot records, cycles since reset, expected outputs.
  bit m_occ [32];
  bit m_chg [32];
  int m_ts  [32];
  int m_cyc, m_free;
  int e_et, e_xt, e_bill;
  bit e_bv, e_eo, e_ee, e_er;

  task automatic check_outputs();
    check_eq("entry_time",   entry_time,   e_et);
    check_eq("exit_time",    exit_time,    e_xt);
    check_eq("total_bill",   total_bill,   e_bill);
    check_eq("bill_valid",   bill_valid,   e_bv);
    check_eq("err_occupied", err_occupied, e_eo);
    check_eq("err_empty",    err_empty,    e_ee);
    check_eq("err_range",    err_range,    e_er);
    check_eq("free_count",   free_count,   m_free);
    check_eq("full",         full,         m_free == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin m_occ[i] = 0; m_chg[i] = 0; end
    m_cyc = 0; m_free = 16;
    e_et = 0; e_xt = 0; e_bill = 0; e_bv = 0; e_eo = 0; e_ee = 0; e_er = 0;
    check_outputs();
  endtask

  task automatic step(input bit er, input int es, input bit wc, input bit xr, input int xs);
    int t, dur, bill;
    bit e_in, x_in, x_ok, e_ok;
    entry_req = er; entry_slot = 5'(es); want_charge = wc;
    exit_req  = xr; exit_slot  = 5'(xs);
    t    = m_cyc % 256;
    e_in = es < 16;
    x_in = xs < 16;
    x_ok = xr && x_in && m_occ[xs];
    e_ok = er && e_in && (!m_occ[es] || (x_ok && xs == es));
    e_bv = x_ok;
    e_eo = er && e_in && !e_ok;
    e_ee = xr && x_in && !m_occ[xs];
    e_er = (er && !e_in) || (xr && !x_in);
    if (x_ok) begin
      dur  = (t - m_ts[xs] + 256) % 256;
      bill = dur * (m_chg[xs] ? 19 : 10);
      e_bill = (bill > 255) ? 255 : bill;
      e_xt = t;
      m_occ[xs] = 0; m_chg[xs] = 0;
      m_free++;
    end
    if (e_ok) begin
      m_ts[es] = t; m_occ[es] = 1; m_chg[es] = wc;
      e_et = t;
      m_free--;
    end
    @(posedge clk); #1;
    m_cyc++;
    entry_req = 1'b0; exit_req = 1'b0;
    check_outputs();
  endtask

  task automatic idle_to(input int t);
    int guard = 0;
    while ((m_cyc % 256) != t && guard < 300) begin
      step(0, 0, 0, 0, 0);
      guard++;
    end
  endtask

  int b_ts [16];

  initial begin
    do_reset();

    // standard billing
    idle_to(5);  step(1, 3, 0, 0, 0);
    idle_to(17); step(0, 0, 0, 1, 3);
    check_eq("std_bill", total_bill, 120);
    check_eq("std_exit_time", exit_time, 17);
    check_eq("std_free", free_count, 16);

    // charging billing and double exit
    idle_to(10); step(1, 7, 1, 0, 0);
    idle_to(20); step(0, 0, 0, 1, 7);
    check_eq("chg_bill", total_bill, 190);
    step(0, 0, 0, 1, 7);
    check_eq("dbl_exit_err_empty", err_empty, 1);
    check_eq("dbl_exit_bill_valid", bill_valid, 0);
    check_eq("dbl_exit_bill_hold", total_bill, 190);

    // wrap and saturation
    idle_to(250); step(1, 4, 0, 0, 0);
    idle_to(4);   step(0, 0, 0, 1, 4);
    check_eq("wrap_bill", total_bill, 100);
    idle_to(0);   step(1, 5, 1, 0, 0);
    idle_to(30);  step(0, 0, 0, 1, 5);
    check_eq("sat_bill", total_bill, 255);

    // fill, occupied, range
    for (int s = 0; s < 16; s++) step(1, s, s % 2, 0, 0);
    check_eq("full_flag", full, 1);
    check_eq("full_free", free_count, 0);
    step(1, 5, 0, 0, 0);
    check_eq("occ_err", err_occupied, 1);
    check_eq("occ_free", free_count, 0);
    step(1, 16, 0, 0, 0);
    check_eq("range_entry", err_range, 1);
    step(0, 0, 0, 1, 16);
    check_eq("range_exit", err_range, 1);

    // simultaneous same-slot events
    step(1, 2, 0, 1, 2);
    check_eq("swap_bill_valid", bill_valid, 1);
    check_eq("swap_free", free_count, 0);
    check_eq("swap_entry_time", entry_time, (m_cyc - 1) % 256);
    step(0, 0, 0, 1, 9);
    step(1, 9, 0, 1, 9);
    check_eq("swap_empty_err", err_empty, 1);
    check_eq("swap_empty_free", free_count, 0);

    // reset mid-operation
    do_reset();
    for (int s = 0; s < 4; s++) step(1, s, 0, 0, 0);
    do_reset();
    check_eq("rst_free", free_count, 16);
    step(0, 0, 0, 1, 0);
    check_eq("rst_exit_err_empty", err_empty, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 1), $urandom_range(0, 17), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 17));

    // prescaled instance
    do_reset();
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 10)) step(0, 0, 0, 0, 0);
      b_entry_req = 1'b1; b_entry_slot = 4'(k); b_want_charge = k % 2;
      b_ts[k] = (m_cyc / 3) % 65536;
      step(0, 0, 0, 0, 0);
      b_entry_req = 1'b0;
      check_eq("b_entry_time", b_entry_time, b_ts[k]);
    end
    check_eq("b_free_after_entry", b_free_count, 10);
    for (int k = 0; k < 6; k++) begin
      int t;
      repeat ($urandom_range(1, 20)) step(0, 0, 0, 0, 0);
      b_exit_req = 1'b1; b_exit_slot = 4'(k);
      t = (m_cyc / 3) % 65536;
      step(0, 0, 0, 0, 0);
      b_exit_req = 1'b0;
      check_eq("b_bill_valid", b_bill_valid, 1);
      check_eq("b_exit_time", b_exit_time, t);
      check_eq("b_total_bill", b_total_bill, (t - b_ts[k]) * ((k % 2) ? 19 : 10));
    end
    check_eq("b_free_after_exit", b_free_count, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_billing_ctrl.md
Name: parking_billing_ctrl

Overview:
Parametrised parking-lot controller that tracks per-slot occupancy, entry timestamps and charging requests, and computes a bill on exit. It is the next-generation replacement for the fixed 16-slot billing logic. Slot count, time-base width, tariff rates and bill width are parameters. It adds occupancy checking, error reporting, free-slot counting, wrap-safe durations and bill saturation. It sits between the gate sensor front-end and the display/payment logic.

Parameters:
NUM_SLOTS, 16, number of parking slots
SLOT_W, 4, slot index width; must be at least clog2(NUM_SLOTS)
TIME_W, 16, time counter width
TICK_DIV, 1, clk cycles per time unit; must be at least 1
BILL_W, 24, bill width
RATE_STD, 10, cost per time unit, non-charging
RATE_CHG, 19, cost per time unit, charging

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
entry_req  in  1  entry event (one-cycle pulse)
entry_slot  in  SLOT_W  slot for entry
want_charge  in  1  charging requested, sampled with entry_req
exit_req  in  1  exit event (one-cycle pulse)
exit_slot  in  SLOT_W  slot for exit
entry_time  out  TIME_W  timestamp of last accepted entry
exit_time  out  TIME_W  timestamp of last accepted exit
total_bill  out  BILL_W  bill of last accepted exit
bill_valid  out  1  one-cycle pulse when total_bill is updated
err_occupied  out  1  pulse: entry rejected, slot occupied
err_empty  out  1  pulse: exit rejected, slot empty
err_range  out  1  pulse: slot index >= NUM_SLOTS on any request
free_count  out  SLOT_W+1  number of unoccupied slots
full  out  1  free_count == 0

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-high.
  - Clears all outputs to 0, except free_count = NUM_SLOTS.
  - Clears the occupancy bitmap, charge bitmap, time counter and prescaler.
  - A reset in mid-operation discards all parked records. The timestamp array need not be cleared.
- Time base:
  - The prescaler counts 0..TICK_DIV-1.
  - On terminal count, time_now increments and wraps modulo 2^TIME_W.
- Latency: a request sampled at edge N updates its outputs and pulses at edge N+1, so they are visible for exactly one cycle. Pulse outputs are 0 otherwise.
- Entry accepted (in range, slot free):
  - Store time_now in ts[slot]; set occ[slot] and chg[slot]=want_charge.
  - entry_time <= time_now.
- Exit accepted (in range, slot occupied):
  - dur = (time_now - ts[slot]) mod 2^TIME_W, which is wrap-safe.
  - bill = dur * (chg ? RATE_CHG : RATE_STD), computed at full product width.
  - If bill > 2^BILL_W-1, saturate to all-ones.
  - Clear occ[slot] and chg[slot]; exit_time <= time_now; bill_valid <= 1.
- Rejected requests change no state, except the matching error pulse. An out-of-range index raises err_range only.
- Simultaneous entry and exit:
  - Both are evaluated against the pre-edge occupancy.
  - Different slots: both are processed independently.
  - Same slot and it is occupied: exit is billed, then entry re-occupies the slot with a new timestamp. free_count is unchanged.
  - Same slot and it is empty: err_empty is raised and the entry is accepted.
- free_count:
  - +1 per accepted exit, -1 per accepted entry, net per cycle.
  - It can never go below 0 or above NUM_SLOTS, because occupancy checks guarantee this.
- A duration of 0 (entry and exit in the same time unit) yields bill 0 with bill_valid=1.

Decomposition:
- Package parking_pkg holds:
  - the default rate constants;
  - the helper function for the saturating multiply;
  - the request-status encoding (ACCEPT, ERR_OCC, ERR_EMPTY, ERR_RANGE).
- One sub-module, parking_time_base: prescaler plus TIME_W wrapping counter, with outputs time_now and tick.
- Slot storage is inline: the ts array plus the occ and chg bitmaps.

Test Plan:
- Standard billing (TICK_DIV=1, defaults): entry slot 3 at time 5 with want_charge=0, exit slot 3 at time 17 -> bill_valid pulse, total_bill=120, exit_time=17, free_count returns to 16.
- Charging billing: entry slot 7 at time 10 with want_charge=1, exit at time 20 -> total_bill=190. A second exit of slot 7 -> err_empty=1, bill_valid=0, total_bill holds 190.
- Wrap and saturation (TIME_W=8, BILL_W=8):
  - entry at 250, exit at 4 -> dur=10, bill 100;
  - entry at 0, exit at 30 with charge -> 570 saturates to 255.
- Full and occupancy: fill slots 0..15 -> full=1, free_count=0. Entry to slot 5 -> err_occupied, state unchanged. Index 16 with SLOT_W=5 -> err_range.
- Simultaneous events: exit slot 2 and entry slot 2 in the same cycle while slot 2 is occupied -> bill issued, slot 2 re-occupied with the new timestamp, free_count unchanged.
- Reset mid-operation: with 4 slots occupied, assert rst for one cycle -> free_count=16, all outputs 0. Exit of a previously occupied slot -> err_empty.
